exec_lane_alu: RTL and testbench

Pipelined, parametrised execution-stage ALU for the vector datapath. Accepts one operation per cycle over a valid/ready handshake and returns a registered result two cycles later. Supports integer and Q-format fixed-point ADD/SUB/MUL in scalar (lane 0) and vector (all lanes) modes. Sits between operand fetch/decode and the memory stage, with per-lane saturation flags and an illegal-opcode flag.

---
 rtl/exec_lane_alu.sv | 201 ++++++++++++++++++++
 tb/tb_exec_lane_alu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_lane_alu.sv
// exec_lane_alu
// Two-stage pipelined execution ALU for the vector datapath. A beat accepted
// over the in_valid/in_ready handshake is captured in stage 1. Stage 2 computes
// the lane results and registers them for the out_valid/out_ready handshake.
// Integer ops wrap. Fixed-point (Q-format) ops saturate per lane.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake (in_ready is combinational from out_ready)
//   opcode[4:3]         mode: 00 scalar int, 01 scalar fixed, 10 vector int, 11 vector fixed
//   opcode[2:0]         op: 000 ADD, 001 SUB, 010 MUL, others illegal
//   a, b                packed operands, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready result beat handshake
//   result              packed lane results, same packing as a/b
//   sat                 per-lane clamp flag (fixed modes only)
//   illegal             unsupported op; result and sat are zero
module exec_lane_alu #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4,
  parameter int FRAC_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [4:0]                      opcode,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] result,
  output logic [NUM_LANES-1:0]            sat,
  output logic                            illegal
);

  localparam int W  = DATA_WIDTH;
  localparam int VW = NUM_LANES * DATA_WIDTH;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010
  } op_e;

  // Saturation bounds expressed in the 2W-bit working width.
  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic          s1_valid_q, s1_valid_d;
  logic [4:0]    s1_opcode_q, s1_opcode_d;
  logic [VW-1:0] s1_a_q, s1_a_d;
  logic [VW-1:0] s1_b_q, s1_b_d;

  logic          out_valid_q, out_valid_d;
  logic [VW-1:0] result_q, result_d;
  logic [NUM_LANES-1:0] sat_q, sat_d;
  logic          illegal_q, illegal_d;

  logic s2_adv, s1_adv;

  logic [VW-1:0]        calc_result;
  logic [NUM_LANES-1:0] calc_sat;
  logic                 calc_illegal;
  logic                 is_fixed, is_vector;
  op_e                  op_sel;

  logic signed [2*W-1:0] ext_a, ext_b;
  logic signed [2*W-1:0] full_sum, full_diff, full_prod, prod_shift;
  logic signed [2*W-1:0] lane_wide;
  logic [W-1:0]          int_val;

  // Lane datapath. Operands are sign-extended to 2W bits so that sums,
  // differences and full products are exact before wrapping or clamping.
  always_comb begin
    calc_result  = '0;
    calc_sat     = '0;
    is_fixed     = s1_opcode_q[3];
    is_vector    = s1_opcode_q[4];
    op_sel       = op_e'(s1_opcode_q[2:0]);
    calc_illegal = (s1_opcode_q[2:0] > 3'd2);
    ext_a        = '0;
    ext_b        = '0;
    full_sum     = '0;
    full_diff    = '0;
    full_prod    = '0;
    prod_shift   = '0;
    lane_wide    = '0;
    int_val      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ext_a      = {{W{s1_a_q[i*W+W-1]}}, s1_a_q[i*W +: W]};
      ext_b      = {{W{s1_b_q[i*W+W-1]}}, s1_b_q[i*W +: W]};
      full_sum   = ext_a + ext_b;
      full_diff  = ext_a - ext_b;
      full_prod  = ext_a * ext_b;
      // Arithmetic shift truncates toward minus infinity.
      prod_shift = full_prod >>> FRAC_BITS;
      lane_wide  = '0;
      int_val    = '0;
      case (op_sel)
        OP_ADD: begin
          lane_wide = full_sum;
          int_val   = full_sum[W-1:0];
        end
        OP_SUB: begin
          lane_wide = full_diff;
          int_val   = full_diff[W-1:0];
        end
        OP_MUL: begin
          lane_wide = prod_shift;
          int_val   = full_prod[W-1:0];
        end
        default: begin
          lane_wide = '0;
          int_val   = '0;
        end
      endcase
      // Scalar modes only produce lane 0; illegal ops produce nothing.
      if (!calc_illegal && (is_vector || i == 0)) begin
        if (is_fixed) begin
          if (lane_wide > SAT_MAX) begin
            calc_result[i*W +: W] = SAT_MAX[W-1:0];
            calc_sat[i]           = 1'b1;
          end else if (lane_wide < SAT_MIN) begin
            calc_result[i*W +: W] = SAT_MIN[W-1:0];
            calc_sat[i]           = 1'b1;
          end else begin
            calc_result[i*W +: W] = lane_wide[W-1:0];
          end
        end else begin
          calc_result[i*W +: W] = int_val;
        end
      end
    end
  end

  // Flow control and next-state. Stage 2 advances when its slot is empty or
  // being drained; stage 1 advances when empty or when stage 2 advances.
  // Stage 2 output registers only change when a new valid beat arrives, so
  // they hold through stalls and bubbles.
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_ready    = s1_adv;

    s1_valid_d  = s1_valid_q;
    s1_opcode_d = s1_opcode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    illegal_d   = illegal_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_opcode_d = opcode;
        s1_a_d      = a;
        s1_b_d      = b;
      end
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d  = calc_result;
        sat_d     = calc_sat;
        illegal_d = calc_illegal;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_lane_alu.sv
// tb_exec_lane_alu
// Directed bench for exec_lane_alu with default parameters
// (16-bit lanes, 4 lanes, 8 fractional bits).
module tb_exec_lane_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  sat;
  logic        illegal;

  int compared   = 0;
  int mismatched = 0;

  exec_lane_alu #(
    .DATA_WIDTH(16),
    .NUM_LANES (4),
    .FRAC_BITS (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .sat      (sat),
    .illegal  (illegal)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat on the input side just after a falling edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [63:0] va,
                               input logic [63:0] vb);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a        = va;
    b        = vb;
  endtask

  // Sends one beat with out_ready held high and checks latency and outputs.
  task automatic runBeat(input string tag, input logic [4:0] op,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] exp_res, input logic [3:0] exp_sat,
                         input logic exp_ill);
    applyStimulus(op, va, vb);
    #1;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = '0;
    a        = '0;
    b        = '0;
    checkOutput({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    checkOutput({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
  endtask

  // Backpressure stream operands and their wrapped vector-ADD sums.
  function automatic logic [63:0] bpA(input int k);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'(k * 32'h3000 + l * 32'h11 + 32'h100);
    return r;
  endfunction

  function automatic logic [63:0] bpB(input int k);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'(k * 32'h0101 + l * 32'h2000);
    return r;
  endfunction

  function automatic logic [63:0] bpExp(input int k);
    logic [63:0] r;
    logic [63:0] ra;
    logic [63:0] rb;
    ra = bpA(k);
    rb = bpB(k);
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = ra[l*16 +: 16] + rb[l*16 +: 16];
    return r;
  endfunction

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    int          stale;
    bit          holding;
    logic [63:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = '0;
    a         = '0;
    b         = '0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_sat", 64'(sat), 64'd0);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Scalar integer ADD wraps; upper lanes are ignored.
    runBeat("int_add_wrap", 5'b00000,
            64'h1111_2222_3333_7FFF, 64'h4444_5555_6666_0001,
            64'h0000_0000_0000_8000, 4'b0000, 1'b0);

    // Vector fixed MUL with clamping on lanes 1 and 2.
    runBeat("vfix_mul", 5'b11010,
            64'hFF00_8000_7F00_0180, 64'h0100_0400_0400_0200,
            64'hFF00_8000_7FFF_0300, 4'b0110, 1'b0);

    // Scalar fixed SUB clamps low; upper lanes would clamp but must not.
    runBeat("sfix_sub_sat", 5'b01001,
            64'h7FFF_7FFF_7FFF_8000, 64'h8000_8000_8000_0001,
            64'h0000_0000_0000_8000, 4'b0001, 1'b0);

    // Illegal opcodes.
    runBeat("illegal_00111", 5'b00111,
            64'h1234_5678_9ABC_DEF0, 64'h0001_0002_0003_0004,
            64'h0, 4'b0000, 1'b1);
    runBeat("illegal_10101", 5'b10101,
            64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF,
            64'h0, 4'b0000, 1'b1);

    // Vector integer MUL keeps the low half of the product.
    runBeat("vint_mul", 5'b10010,
            64'h8000_1234_0003_0100, 64'h0002_0002_FFFF_0100,
            64'h0000_2468_FFFD_0000, 4'b0000, 1'b0);

    // Vector fixed ADD: lane 0 clamps high, lane 2 clamps low.
    runBeat("vfix_add", 5'b11000,
            64'h0001_9000_0100_7000, 64'h0002_9000_FF00_7000,
            64'h0003_8000_0000_7FFF, 4'b0101, 1'b0);

    // Scalar fixed MUL: -1/256 * 0.5 truncates toward minus infinity.
    runBeat("sfix_mul_trunc", 5'b01010,
            64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0080,
            64'h0000_0000_0000_FFFF, 4'b0000, 1'b0);

    // Vector integer SUB wraps.
    runBeat("vint_sub", 5'b10001,
            64'h0000_8000_0010_0005, 64'h0001_0001_0020_0003,
            64'hFFFF_7FFF_FFF0_0002, 4'b0000, 1'b0);

    // Backpressure: six vector ADDs, out_ready low for cycles 3..7.
    sent    = 0;
    recv    = 0;
    holding = 1'b0;
    held    = '0;
    for (cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 6) begin
        in_valid = 1'b1;
        opcode   = 5'b10000;
        a        = bpA(sent);
        b        = bpB(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (sent - recv == 2 && !out_ready)
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      else
        checkOutput("bp_in_ready_high", 64'(in_ready), 64'd1);
      if (out_valid && !out_ready) begin
        if (holding) checkOutput("bp_hold_result", result, held);
        held    = result;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        checkOutput("bp_result", result, bpExp(recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_delivered", 64'(recv), 64'd6);
    checkOutput("bp_cycles", 64'(cyc), 64'd13);

    // Reset mid-stall with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(5'b11000, 64'h0001_9000_0100_7000, 64'h0002_9000_FF00_7000);
    applyStimulus(5'b00111, 64'h0, 64'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("midrst_pre_valid", 64'(out_valid), 64'd1);
    checkOutput("midrst_pre_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_sat", 64'(sat), 64'd0);
    checkOutput("midrst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checkOutput("midrst_no_stale", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
